// File: rtl/can_crc_engine_pkg.sv
// Shared definitions for the CAN CRC engine: FSM state encoding and the
// standard CAN generator polynomials (implicit top term omitted).
package can_crc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_CHECK = 3'd2,
    ST_GEN   = 3'd3,
    ST_DONE  = 3'd4
  } crc_state_t;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam logic [16:0] CAN_CRC17_POLY = 17'h1685B;
  localparam logic [20:0] CAN_CRC21_POLY = 21'h102899;

  function automatic logic state_is_busy(input crc_state_t s);
    return (s == ST_ACCUM) || (s == ST_CHECK) || (s == ST_GEN);
  endfunction

endpackage

// File: rtl/can_crc_engine_if.sv
// Framing strobes from the frame FSM and CRC status back to it.
// master = frame FSM side, slave = CRC engine side.
interface can_crc_engine_if #(
  parameter int CRC_WIDTH = 15
);
  logic                 Start;
  logic                 Abort;
  logic                 Mode;
  logic                 Bit_In;
  logic                 Stuff_Bit;
  logic                 Data_End;
  logic [CRC_WIDTH-1:0] CRC_Value;
  logic                 Tx_Bit;
  logic                 Busy;
  logic                 CRC_Done;
  logic                 CRC_Error;

  modport master (
    output Start, Abort, Mode, Bit_In, Stuff_Bit, Data_End,
    input  CRC_Value, Tx_Bit, Busy, CRC_Done, CRC_Error
  );

  modport slave (
    input  Start, Abort, Mode, Bit_In, Stuff_Bit, Data_End,
    output CRC_Value, Tx_Bit, Busy, CRC_Done, CRC_Error
  );
endinterface

// File: rtl/can_crc_engine_bit_tick.sv
// Bit-time divider: one-cycle tick every CLKS_PER_BIT clocks; a clear
// realigns the count so the next tick lands a full bit time later.
module can_bit_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_tick;

  // next count: wrap at the last slot, forced to zero on clear
  always_comb begin
    w_count_nxt = r_count + CNT_ONE;
    if (i_clear) begin
      w_count_nxt = CNT_ZERO;
    end else if (r_count == CNT_LAST) begin
      w_count_nxt = CNT_ZERO;
    end else begin
      w_count_nxt = r_count + CNT_ONE;
    end
  end

  // tick is registered alongside the count it decodes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= CNT_ZERO;
      r_tick  <= (CNT_LAST == CNT_ZERO);
    end else begin
      r_count <= w_count_nxt;
      r_tick  <= (w_count_nxt == CNT_LAST);
    end
  end

  assign o_tick = r_tick;
endmodule

// File: rtl/can_crc_engine.sv
// Serial CAN CRC engine: accumulates frame bits, then either checks the
// received CRC field (RX) or serialises the computed CRC (TX).
module can_crc_engine
  import can_crc_pkg::*;
#(
  parameter int                   CRC_WIDTH    = 15,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY     = CRC_WIDTH'(CAN_CRC15_POLY),
  parameter logic [CRC_WIDTH-1:0] CRC_INIT     = {CRC_WIDTH{1'b0}},
  parameter int                   CLKS_PER_BIT = 10
) (
  input logic             Clock_TB,
  input logic             Reset_N,
  can_crc_engine_if.slave bus
);
  localparam int IDX_W = $clog2(CRC_WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(CRC_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  crc_state_t           r_state, w_state_nxt;
  logic [CRC_WIDTH-1:0] r_crc, w_crc_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt, w_idx_dec;
  logic                 r_mode, w_mode_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_busy, r_done;
  logic                 w_tick, w_valid_tick, w_mismatch;

  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] crc,
                                                    input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[CRC_WIDTH-1];
    return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_WIDTH{1'b0}});
  endfunction

  can_bit_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .i_clk   (Clock_TB),
    .i_rst_n (Reset_N),
    .i_clear (bus.Start),
    .o_tick  (w_tick)
  );

  assign w_valid_tick = w_tick & ~bus.Stuff_Bit;

  // next-state and datapath: Abort beats Start beats tick processing
  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_idx_nxt   = r_idx;
    w_mode_nxt  = r_mode;
    w_tx_nxt    = r_tx;
    w_err_nxt   = r_err;
    w_idx_dec   = r_idx - IDX_ONE;
    w_mismatch  = bus.Bit_In ^ r_crc[r_idx];
    if (bus.Abort) begin
      w_state_nxt = ST_IDLE;
      w_crc_nxt   = CRC_INIT;
      w_idx_nxt   = IDX_TOP;
      w_tx_nxt    = 1'b1;
      w_err_nxt   = 1'b0;
    end else if (bus.Start) begin
      w_state_nxt = ST_ACCUM;
      w_crc_nxt   = CRC_INIT;
      w_idx_nxt   = IDX_TOP;
      w_mode_nxt  = bus.Mode;
      w_tx_nxt    = 1'b1;
      w_err_nxt   = 1'b0;
    end else if (w_valid_tick) begin
      case (r_state)
        ST_ACCUM: begin
          w_crc_nxt = crc_step(r_crc, bus.Bit_In);
          if (bus.Data_End && r_mode) begin
            w_state_nxt = ST_GEN;
            w_tx_nxt    = w_crc_nxt[CRC_WIDTH-1];
          end else if (bus.Data_End) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end
        ST_CHECK: begin
          w_err_nxt = r_err | w_mismatch;
          if (r_idx == IDX_ZERO) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt = w_idx_dec;
          end
        end
        ST_GEN: begin
          // Tx_Bit always shows the bit for the upcoming bit time
          if (r_idx == IDX_ZERO) begin
            w_state_nxt = ST_DONE;
            w_tx_nxt    = 1'b1;
          end else begin
            w_idx_nxt = w_idx_dec;
            w_tx_nxt  = r_crc[w_idx_dec];
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // state and output registers
  always_ff @(posedge Clock_TB or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state <= ST_IDLE;
      r_crc   <= CRC_INIT;
      r_idx   <= IDX_TOP;
      r_mode  <= 1'b0;
      r_tx    <= 1'b1;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_crc   <= w_crc_nxt;
      r_idx   <= w_idx_nxt;
      r_mode  <= w_mode_nxt;
      r_tx    <= w_tx_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= state_is_busy(w_state_nxt);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.CRC_Value = r_crc;
  assign bus.Tx_Bit    = r_tx;
  assign bus.Busy      = r_busy;
  assign bus.CRC_Done  = r_done;
  assign bus.CRC_Error = r_err;
endmodule

// File: tb/tb_can_crc_engine.sv
// Scoreboard bench for can_crc_engine: a CRC-15 instance with a 4-clock bit
// time and a CRC-17 instance ticking every clock, checked against hand values.
module tb_can_crc_engine;
  import can_crc_pkg::*;

  localparam int C15 = 4;

  typedef struct {
    string       tag;
    logic [31:0] crc;
    logic        tx;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q15[$];
  exp_t q17[$];
  exp_t last15;
  event ev15, ev17;

  always #5 clk = ~clk;

  can_crc_engine_if #(.CRC_WIDTH(15)) b15 ();
  can_crc_engine_if #(.CRC_WIDTH(17)) b17 ();

  can_crc_engine #(.CRC_WIDTH(15), .CRC_POLY(CAN_CRC15_POLY), .CRC_INIT(15'h0000),
                   .CLKS_PER_BIT(C15)) dut15 (.Clock_TB(clk), .Reset_N(rst_n), .bus(b15));
  can_crc_engine #(.CRC_WIDTH(17), .CRC_POLY(CAN_CRC17_POLY), .CRC_INIT(17'h00000),
                   .CLKS_PER_BIT(1)) dut17 (.Clock_TB(clk), .Reset_N(rst_n), .bus(b17));

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void push15(input string tag, input logic [31:0] crc,
                                 input logic tx, input logic busy, input logic done, input logic err);
    exp_t e;
    e.tag = tag; e.crc = crc; e.tx = tx; e.busy = busy; e.done = done; e.err = err;
    q15.push_back(e);
    last15 = e;
  endfunction

  function automatic void push17(input string tag, input logic [31:0] crc,
                                 input logic busy, input logic done, input logic err);
    exp_t e;
    e.tag = tag; e.crc = crc; e.tx = 1'b1; e.busy = busy; e.done = done; e.err = err;
    q17.push_back(e);
  endfunction

  initial begin : mon15
    exp_t e;
    forever begin
      @(ev15);
      @(negedge clk);
      if (q15.size() == 0) begin
        n_chk++;
        $display("FAIL q15_underflow: got empty queue expected an entry");
      end else begin
        e = q15.pop_front();
        cmp({e.tag, ".crc"},  32'(b15.CRC_Value), e.crc);
        cmp({e.tag, ".tx"},   32'(b15.Tx_Bit),    32'(e.tx));
        cmp({e.tag, ".busy"}, 32'(b15.Busy),      32'(e.busy));
        cmp({e.tag, ".done"}, 32'(b15.CRC_Done),  32'(e.done));
        cmp({e.tag, ".err"},  32'(b15.CRC_Error), 32'(e.err));
      end
    end
  end

  initial begin : mon17
    exp_t e;
    forever begin
      @(ev17);
      @(negedge clk);
      if (q17.size() == 0) begin
        n_chk++;
        $display("FAIL q17_underflow: got empty queue expected an entry");
      end else begin
        e = q17.pop_front();
        cmp({e.tag, ".crc"},  32'(b17.CRC_Value), e.crc);
        cmp({e.tag, ".tx"},   32'(b17.Tx_Bit),    32'(e.tx));
        cmp({e.tag, ".busy"}, 32'(b17.Busy),      32'(e.busy));
        cmp({e.tag, ".done"}, 32'(b17.CRC_Done),  32'(e.done));
        cmp({e.tag, ".err"},  32'(b17.CRC_Error), 32'(e.err));
      end
    end
  end

  task automatic start15(input string tag, input logic mode);
    b15.Start = 1'b1; b15.Mode = mode;
    @(posedge clk); #1;
    b15.Start = 1'b0;
    push15(tag, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0); ->ev15;
  endtask

  // one bit time; also checks nothing moved one clock before the tick
  task automatic bit15(input string tag, input logic b, input logic st, input logic de,
                       input logic [31:0] crc, input logic tx, input logic busy,
                       input logic done, input logic err);
    exp_t p;
    b15.Bit_In = b; b15.Stuff_Bit = st; b15.Data_End = de;
    repeat (C15 - 1) @(posedge clk);
    #1;
    p = last15; p.tag = {tag, "_pre"};
    q15.push_back(p); ->ev15;
    @(posedge clk); #1;
    b15.Stuff_Bit = 1'b0; b15.Data_End = 1'b0;
    push15(tag, crc, tx, busy, done, err); ->ev15;
  endtask

  task automatic abort15(input string tag, input logic with_start);
    b15.Abort = 1'b1; b15.Start = with_start;
    @(posedge clk); #1;
    b15.Abort = 1'b0; b15.Start = 1'b0;
    push15(tag, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0); ->ev15;
  endtask

  // data bits 1,0 with an optional stuff tick (carrying Data_End) between them
  task automatic frame15(input string tag, input logic mode, input logic stuffed);
    start15({tag, "_start"}, mode);
    bit15({tag, "_d1"}, 1'b1, 1'b0, 1'b0, 32'h4599, 1'b1, 1'b1, 1'b0, 1'b0);
    if (stuffed)
      bit15({tag, "_dstuff"}, 1'b0, 1'b1, 1'b1, 32'h4599, 1'b1, 1'b1, 1'b0, 1'b0);
    bit15({tag, "_d0"}, 1'b0, 1'b0, 1'b1, 32'h4EAB, mode ? 1'b1 : 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // CRC field: check mode compares Bit_In, gen mode shifts out Tx_Bit
  task automatic field15(input string tag, input logic gen, input int bad_idx, input int stuff_idx);
    logic [14:0] ref_crc;
    logic        err_acc;
    logic        tx_exp;
    logic        b;
    ref_crc = 15'h4EAB;
    err_acc = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      if (i == stuff_idx)
        bit15($sformatf("%s_stuff%0d", tag, i), gen ? 1'b0 : ~ref_crc[i], 1'b1, 1'b1,
              last15.crc, last15.tx, last15.busy, last15.done, last15.err);
      b = gen ? 1'b0 : ((i == bad_idx) ? ~ref_crc[i] : ref_crc[i]);
      if (!gen && i == bad_idx) err_acc = 1'b1;
      if (gen && i != 0) tx_exp = ref_crc[i-1];
      else tx_exp = 1'b1;
      bit15($sformatf("%s_f%0d", tag, i), b, 1'b0, 1'b0, 32'h4EAB, tx_exp,
            i != 0, i == 0, err_acc);
    end
  endtask

  task automatic bit17(input string tag, input logic b, input logic de, input logic [31:0] crc,
                       input logic busy, input logic done, input logic err);
    b17.Bit_In = b; b17.Data_End = de;
    @(posedge clk); #1;
    b17.Data_End = 1'b0;
    push17(tag, crc, busy, done, err); ->ev17;
  endtask

  initial begin : stim
    logic [16:0] ref17;
    rst_n = 1'b0;
    b15.Start = 1'b0; b15.Abort = 1'b0; b15.Mode = 1'b0;
    b15.Bit_In = 1'b0; b15.Stuff_Bit = 1'b0; b15.Data_End = 1'b0;
    b17.Start = 1'b0; b17.Abort = 1'b0; b17.Mode = 1'b0;
    b17.Bit_In = 1'b0; b17.Stuff_Bit = 1'b0; b17.Data_End = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push15("por", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0); ->ev15;
    push17("por17", 32'h0, 1'b0, 1'b0, 1'b0); ->ev17;

    // ticks in IDLE do nothing
    b15.Bit_In = 1'b1; b15.Data_End = 1'b1;
    repeat (3 * C15) @(posedge clk);
    #1 b15.Data_End = 1'b0;
    push15("idle_ticks", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0); ->ev15;

    // async reset in the middle of ACCUM
    start15("rst_start", 1'b0);
    bit15("rst_d1", 1'b1, 1'b0, 1'b0, 32'h4599, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    push15("async_rst", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0); ->ev15;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single bit with Data_End, then Abort and Start together -> IDLE
    start15("t2_start", 1'b0);
    bit15("t2_d1", 1'b1, 1'b0, 1'b1, 32'h4599, 1'b1, 1'b1, 1'b0, 1'b0);
    abort15("t2_abort_start", 1'b1);

    // good check, then done held across another bit time
    frame15("t3", 1'b0, 1'b0);
    field15("t3", 1'b0, -1, -1);
    bit15("t3_hold", 1'b0, 1'b0, 1'b0, 32'h4EAB, 1'b1, 1'b0, 1'b1, 1'b0);

    // bit 7 of the CRC field corrupted
    frame15("t4", 1'b0, 1'b0);
    field15("t4", 1'b0, 7, -1);

    // generate mode
    frame15("t5", 1'b1, 1'b0);
    field15("t5", 1'b1, -1, -1);

    // stuff bits in data and in the CRC field
    frame15("t6c", 1'b0, 1'b1);
    field15("t6c", 1'b0, -1, 10);
    frame15("t6g", 1'b1, 1'b1);
    field15("t6g", 1'b1, -1, 6);

    // abort in CHECK after an error clears everything
    frame15("t6a", 1'b0, 1'b0);
    bit15("t6a_f14", 1'b0, 1'b0, 1'b0, 32'h4EAB, 1'b1, 1'b1, 1'b0, 1'b1);
    abort15("t6a_abort", 1'b0);

    // CRC-17 at one bit per clock
    b17.Start = 1'b1; b17.Mode = 1'b0;
    @(posedge clk); #1;
    b17.Start = 1'b0;
    push17("t7_start", 32'h0, 1'b1, 1'b0, 1'b0); ->ev17;
    bit17("t7_d1", 1'b1, 1'b0, 32'h1685B, 1'b1, 1'b0, 1'b0);
    bit17("t7_d0", 1'b0, 1'b1, 32'h1B8ED, 1'b1, 1'b0, 1'b0);
    ref17 = 17'h1B8ED;
    for (int i = 16; i >= 0; i--)
      bit17($sformatf("t7_f%0d", i), ref17[i], 1'b0, 32'h1B8ED, i != 0, i == 0, 1'b0);

    repeat (5) @(posedge clk);
    cmp("q15_drained", 32'(q15.size()), 32'd0);
    cmp("q17_drained", 32'(q17.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
